bp_history_ckpt: RTL
====================

Name: bp_history_ckpt

Overview:
- Parametrised successor to the front-end global-history logic.
- Owns the speculative global branch history, the committed history and an internal checkpoint table indexed by fetch ID, so the mispredict path supplies only a fetch ID and branch position instead of a full history vector.
- Shifts up to NUM_BR conditional outcomes per fetch block per cycle and raises a stall when the checkpoint window is full.
- Sits between the branch predictor (prediction side) and the branch ROB / branch XU (commit and mispredict side).

Parameters:
- HIST_LEN, 16: global history width in bits.
- NUM_BR, 2: maximum conditional branches predicted per fetch block.
- ID_BITS, 3: fetch ID width; checkpoint depth DEPTH = 2^ID_BITS; at most DEPTH-1 blocks in flight.
- CNT_W = $clog2(NUM_BR+1): derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_predValid  in  1  fetch block prediction accepted by front end this cycle
- IN_predBrCnt  in  CNT_W  conditional branches predicted in block (0..NUM_BR)
- IN_predTakenLast  in  1  outcome of the last counted branch (earlier ones are not-taken by construction)
- OUT_fetchID  out  ID_BITS  fetch ID assigned to the current block
- OUT_stall  out  1  checkpoint window full; prediction not accepted
- OUT_history  out  HIST_LEN  speculative history, used for the current prediction
- IN_comValid  in  1  oldest in-flight block retires
- IN_comBrCnt  in  CNT_W  conditional branches retired in that block
- IN_comTakenLast  in  1  outcome of its last retired conditional branch
- OUT_comFetchID  out  ID_BITS  fetch ID of the oldest in-flight block
- OUT_comHistory  out  HIST_LEN  committed history
- IN_mispr  in  1  branch mispredict
- IN_misprFetchID  in  ID_BITS  block containing the mispredicted branch
- IN_misprBrIdx  in  CNT_W  count of conditional branches in that block before it
- IN_misprTaken  in  1  resolved outcome
- IN_flush  in  1  full pipeline flush back to committed state
- IN_rdFetchID  in  ID_BITS  checkpoint read address (for predictor update)
- OUT_rdHist  out  HIST_LEN  checkpoint contents, registered, 1-cycle latency

Behaviour:
- Reset, while rst is high:
  - OUT_history, OUT_comHistory, OUT_rdHist = 0.
  - fetch pointer = 0, commit pointer = 0, OUT_stall = 0.
  - Checkpoint contents are don't-care.
  - rst wins over every other input in the same cycle.
- inflight = (fetchPtr - comPtr) mod DEPTH.
- OUT_stall = (inflight == DEPTH-1). This is combinational from the pointers only.
- Shift rule shift(h, n, t):
  - n = 0 leaves h unchanged.
  - Otherwise h = {h[HIST_LEN-1-n:0], (n-1) zeros, t}, i.e. newest bit in the LSB.
- Accepted prediction (IN_predValid && !OUT_stall && !IN_mispr && !IN_flush):
  - ckpt[fetchPtr] <= OUT_history (the value before the update).
  - OUT_history <= shift(OUT_history, IN_predBrCnt, IN_predTakenLast).
  - fetchPtr <= fetchPtr+1, wrapping mod DEPTH.
  - With IN_predBrCnt = 0 the block is still checkpointed and the ID is still consumed.
  - IN_predValid while stalled is ignored: no state changes.
- Commit (IN_comValid && inflight != 0):
  - OUT_comHistory <= shift(OUT_comHistory, IN_comBrCnt, IN_comTakenLast).
  - comPtr <= comPtr+1.
  - Commit with inflight == 0 is ignored.
  - Commit is processed in the same cycle as mispr or flush. Under flush, the restored history is the post-commit committed value.
- Mispredict (IN_mispr && !IN_flush), valid only if (IN_misprFetchID - comPtr) mod DEPTH < inflight; otherwise ignored:
  - OUT_history <= shift(ckpt[IN_misprFetchID], IN_misprBrIdx+1, IN_misprTaken).
  - fetchPtr <= IN_misprFetchID+1.
  - Any same-cycle prediction is dropped.
  - ckpt[IN_misprFetchID] is not modified.
- Flush (IN_flush):
  - OUT_history <= next committed history (includes a same-cycle commit).
  - fetchPtr <= next comPtr.
  - Same-cycle prediction and mispredict are dropped.
- Priority: rst > flush > mispr > pred. Commit is independent except as stated above.
- Read port: OUT_rdHist <= ckpt[IN_rdFetchID] every cycle. Same-cycle write-then-read of the same entry returns the old value.
- All arithmetic is unsigned modulo 2^ID_BITS. No combinational path from IN_* to OUT_stall.

Test Plan (HIST_LEN=8, NUM_BR=2, ID_BITS=2):
- Reset, then three predictions with (cnt, taken) = (1,1), (2,0), (0,x):
  - OUT_history goes 0x00 → 0x01 → 0x04 → 0x04.
  - OUT_fetchID goes 0 → 1 → 2 → 3.
  - OUT_stall = 1 after the third prediction.
  - A fourth predValid is ignored.
- From the previous state, mispr with ID=1, BrIdx=0, taken=1:
  - OUT_history = 0x03 (ckpt[1] = 0x01 shifted by 1, taken).
  - OUT_fetchID = 2, OUT_stall = 0.
- Commit (2,1) together with flush in the same cycle from history 0x04, comHistory 0x00:
  - OUT_comHistory = 0x01, OUT_history = 0x01.
  - OUT_fetchID = OUT_comFetchID = 1.
- Mispr with an ID outside the in-flight window (e.g. ID = comPtr-1): no change to any output.
- Wrap-around test:
  - Run 10 predictions interleaved with commits; fetch IDs wrap 3 → 0.
  - A mispredict on a wrapped ID restores the correct checkpoint.
  - OUT_rdHist returns the stored value one cycle after IN_rdFetchID.
- Assert rst mid-stream with pred, mispr, flush and commit all active: the next cycle shows all outputs 0 and pointers 0.

Source files
------------

// File: rtl/bp_history_ckpt.sv
// bp_history_ckpt: speculative/committed global branch history with a fetch-ID checkpoint table.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   IN_pred*  / OUT_fetchID, OUT_stall  prediction side: shift outcomes, assign fetch ID, window-full stall
//   OUT_history                         speculative history for the current prediction
//   IN_com*   / OUT_comFetchID          retire oldest in-flight block into the committed history
//   OUT_comHistory                      committed history
//   IN_mispr*                           restore history from a checkpoint plus the resolved outcome
//   IN_flush                            restore history and fetch pointer to the committed state
//   IN_rdFetchID / OUT_rdHist           registered checkpoint read port (1-cycle latency)
module bp_history_ckpt #(
    parameter int HIST_LEN = 16,
    parameter int NUM_BR   = 2,
    parameter int ID_BITS  = 3,
    localparam int CNT_W   = $clog2(NUM_BR + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                IN_predValid,
    input  logic [CNT_W-1:0]    IN_predBrCnt,
    input  logic                IN_predTakenLast,
    output logic [ID_BITS-1:0]  OUT_fetchID,
    output logic                OUT_stall,
    output logic [HIST_LEN-1:0] OUT_history,
    input  logic                IN_comValid,
    input  logic [CNT_W-1:0]    IN_comBrCnt,
    input  logic                IN_comTakenLast,
    output logic [ID_BITS-1:0]  OUT_comFetchID,
    output logic [HIST_LEN-1:0] OUT_comHistory,
    input  logic                IN_mispr,
    input  logic [ID_BITS-1:0]  IN_misprFetchID,
    input  logic [CNT_W-1:0]    IN_misprBrIdx,
    input  logic                IN_misprTaken,
    input  logic                IN_flush,
    input  logic [ID_BITS-1:0]  IN_rdFetchID,
    output logic [HIST_LEN-1:0] OUT_rdHist
);
    localparam int DEPTH = 1 << ID_BITS;

    // Earlier branches in a block are not-taken, so shifting by n inserts n-1 zeros then the last outcome.
    function automatic logic [HIST_LEN-1:0] shiftHist(input logic [HIST_LEN-1:0] h,
                                                      input logic [CNT_W:0] n, input logic t);
        shiftHist = (n == '0) ? h : ((h << n) | HIST_LEN'(t));
    endfunction

    logic [HIST_LEN-1:0] ckpt [DEPTH];
    logic [ID_BITS-1:0]  fetchPtr, comPtr, inflight, misprOff, comPtrNext;
    logic [HIST_LEN-1:0] comHistNext;
    logic                comDo, misprOk, predAcc;

    assign inflight       = fetchPtr - comPtr;
    assign OUT_stall      = inflight == ID_BITS'(DEPTH - 1);
    assign OUT_fetchID    = fetchPtr;
    assign OUT_comFetchID = comPtr;
    assign comDo          = IN_comValid && inflight != '0;
    assign comHistNext    = comDo ? shiftHist(OUT_comHistory, {1'b0, IN_comBrCnt}, IN_comTakenLast) : OUT_comHistory;
    assign comPtrNext     = comPtr + ID_BITS'(comDo);
    // Offset from the oldest block tells whether the mispredicted ID is still in flight.
    assign misprOff       = IN_misprFetchID - comPtr;
    assign misprOk        = IN_mispr && !IN_flush && misprOff < inflight;
    assign predAcc        = IN_predValid && !OUT_stall && !IN_mispr && !IN_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_history    <= '0;
            OUT_comHistory <= '0;
            OUT_rdHist     <= '0;
            fetchPtr       <= '0;
            comPtr         <= '0;
        end else begin
            OUT_comHistory <= comHistNext;
            comPtr         <= comPtrNext;
            OUT_rdHist     <= ckpt[IN_rdFetchID];
            if (IN_flush) begin
                OUT_history <= comHistNext;
                fetchPtr    <= comPtrNext;
            end else if (misprOk) begin
                OUT_history <= shiftHist(ckpt[IN_misprFetchID], {1'b0, IN_misprBrIdx} + (CNT_W+1)'(1), IN_misprTaken);
                fetchPtr    <= IN_misprFetchID + ID_BITS'(1);
            end else if (predAcc) begin
                OUT_history <= shiftHist(OUT_history, {1'b0, IN_predBrCnt}, IN_predTakenLast);
                fetchPtr    <= fetchPtr + ID_BITS'(1);
            end
        end
    end

    // Checkpoint storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && predAcc) ckpt[fetchPtr] <= OUT_history;
    end
endmodule
